// File: rtl/cpu_fetch.sv
// cpu_fetch: moxie instruction fetch with a 6-halfword queue, stall hold and flush redirect
module cpu_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00001000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_address_o,
  input  logic [31:0] imem_data_i,
  input  logic        imem_ack_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t state_q, state_d;
  logic [5:0][15:0] q_q, q_d, q_shift;
  logic [2:0] cnt_q, cnt_d, cnt_mid, pop_n;
  logic [31:0] head_pc_q, head_pc_d, fetch_addr_q, fetch_addr_d, addr_q, addr_d;
  logic [31:0] operand_q, operand_d, pc_q, pc_d;
  logic [15:0] opcode_q, opcode_d;
  logic skip_q, skip_d, req_q, req_d, valid_q, valid_d;
  logic is_long, avail, issue, push;
  always_comb begin
    is_long = q_q[0][15:8] inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B,
                                   8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39};
    avail = is_long ? cnt_q >= 3'd3 : cnt_q >= 3'd1;
    issue = !stall_i && !flush_i && avail;
    pop_n = issue ? (is_long ? 3'd3 : 3'd1) : 3'd0;
    cnt_mid = cnt_q - pop_n;
    push = state_q == WAIT && imem_ack_i && !flush_i;
    q_shift = q_q >> {pop_n, 4'd0};
    q_d = q_shift;
    for (int i = 0; i < 6; i++) begin
      if (push && i == int'(cnt_mid)) q_d[i] = skip_q ? imem_data_i[15:0] : imem_data_i[31:16];
      if (push && !skip_q && i == int'(cnt_mid) + 1) q_d[i] = imem_data_i[15:0];
    end
    cnt_d = flush_i ? 3'd0 : cnt_mid + (push ? (skip_q ? 3'd1 : 3'd2) : 3'd0);
    head_pc_d = flush_i ? target_i : head_pc_q + (issue ? (is_long ? 32'd6 : 32'd2) : 32'd0);
    skip_d = flush_i ? target_i[1] : push ? 1'b0 : skip_q;
    fetch_addr_d = flush_i ? {target_i[31:2], 2'b00} : push ? fetch_addr_q + 32'd4 : fetch_addr_q;
    valid_d = flush_i ? 1'b0 : stall_i ? valid_q : avail;
    opcode_d = issue ? q_q[0] : opcode_q;
    operand_d = issue ? (is_long ? {q_q[1], q_q[2]} : 32'd0) : operand_q;
    pc_d = issue ? head_pc_q : pc_q;
  end
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    addr_d = addr_q;
    if (state_q == IDLE && !flush_i && cnt_mid <= 3'd4) begin
      state_d = WAIT;
      req_d = 1'b1;
      addr_d = fetch_addr_q;
    end
    if (state_q != IDLE && imem_ack_i) begin
      state_d = IDLE;
      req_d = 1'b0;
    end
    if (state_q == WAIT && flush_i && !imem_ack_i) state_d = DISCARD;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q <= '0;
      cnt_q <= 3'd0;
      head_pc_q <= RESET_VECTOR;
      fetch_addr_q <= {RESET_VECTOR[31:2], 2'b00};
      addr_q <= {RESET_VECTOR[31:2], 2'b00};
      skip_q <= RESET_VECTOR[1];
      req_q <= 1'b0;
      opcode_q <= 16'd0;
      operand_q <= 32'd0;
      pc_q <= RESET_VECTOR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      head_pc_q <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      addr_q <= addr_d;
      skip_q <= skip_d;
      req_q <= req_d;
      opcode_q <= opcode_d;
      operand_q <= operand_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
    end
  end
  assign imem_req_o = req_q;
  assign imem_address_o = addr_q;
  assign opcode_o = opcode_q;
  assign operand_o = operand_q;
  assign pc_o = pc_q;
  assign valid_o = valid_q;
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: scoreboard bench for cpu_fetch with a latency-configurable memory
module tb_cpu_fetch;
  logic clk_i = 1'b0, rst_i = 1'b1, stall_i = 1'b0, flush_i = 1'b0, force_ack = 1'b0, upd = 1'b0;
  logic [31:0] target_i = 32'd0;
  logic imem_req_o, imem_ack_i, valid_o;
  logic [31:0] imem_address_o, imem_data_i, operand_o, pc_o;
  logic [15:0] opcode_o;
  logic [31:0] mem [0:255];
  int lat = 0, wcnt = 0, cyc = 0, total = 0, bad = 0;
  typedef struct packed {logic [15:0] op; logic [31:0] opd; logic [31:0] pc;} ins_t;
  ins_t sb[$];
  ins_t last_exp;
  int pops_cyc[$];
  cpu_fetch #(.RESET_VECTOR(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .imem_req_o(imem_req_o), .imem_address_o(imem_address_o),
    .imem_data_i(imem_data_i), .imem_ack_i(imem_ack_i), .stall_i(stall_i), .flush_i(flush_i),
    .target_i(target_i), .opcode_o(opcode_o), .operand_o(operand_o), .pc_o(pc_o), .valid_o(valid_o)
  );
  always #5 clk_i = ~clk_i;
  assign imem_ack_i = (imem_req_o && wcnt == lat) || force_ack;
  assign imem_data_i = force_ack ? 32'h1111_2222 : mem[imem_address_o[9:2]];
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    wcnt <= (imem_req_o && !imem_ack_i) ? wcnt + 1 : 0;
    upd <= !stall_i && !flush_i && !rst_i;
  end
  task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk_i)
    if (upd && valid_o && sb.size() > 0) begin
      last_exp = sb.pop_front();
      pops_cyc.push_back(cyc);
      chk("insn", {opcode_o, operand_o, pc_o}, last_exp);
    end
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask
  task automatic exp_push(logic [15:0] op, logic [31:0] opd, logic [31:0] pc);
    sb.push_back({op, opd, pc});
  endtask
  task automatic push_stream(int n);
    for (int i = 0; i < n; i++) exp_push(16'h4000 | 16'(i), 32'd0, 32'(2 * i));
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    force_ack = 1'b0;
    sb.delete();
    pops_cyc.delete();
    repeat (2) step();
    rst_i = 1'b0;
  endtask
  task automatic drain(string tag);
    for (int k = 0; k < 300 && sb.size() > 0; k++) step();
    chk(tag, 80'(sb.size()), 80'd0);
  endtask
  initial begin
    int n;
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    mem[0] = 32'h0000_0200;
    mem[1] = 32'h0E12_0000;
    lat = 0;
    do_reset();
    chk("rst_valid", 80'(valid_o), 80'd0);
    chk("rst_req", 80'(imem_req_o), 80'd0);
    chk("rst_opcode", 80'(opcode_o), 80'd0);
    chk("rst_operand", 80'(operand_o), 80'd0);
    chk("rst_pc", 80'(pc_o), 80'd0);
    chk("rst_addr", 80'(imem_address_o), 80'd0);
    exp_push(16'h0000, 32'd0, 32'd0);
    exp_push(16'h0200, 32'd0, 32'd2);
    exp_push(16'h0E12, 32'd0, 32'd4);
    exp_push(16'h0000, 32'd0, 32'd6);
    step();
    chk("req_rise", 80'(imem_req_o), 80'd1);
    chk("req_addr", 80'(imem_address_o), 80'd0);
    drain("p1_drain");
    chk("p1_nobubble", 80'(pops_cyc[3] - pops_cyc[0]), 80'd3);
    mem[0] = 32'h0000_011A;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'h0000_0000;
    do_reset();
    exp_push(16'h0000, 32'd0, 32'd0);
    exp_push(16'h011A, 32'hDEAD_BEEF, 32'd2);
    exp_push(16'h0000, 32'd0, 32'd8);
    drain("p2_drain");
    chk("p2_long_gap", 80'(pops_cyc[1] - pops_cyc[0]), 80'd2);
    for (int k = 0; k < 256; k++) mem[k] = {16'h4000 | 16'(2 * k), 16'h4000 | 16'(2 * k + 1)};
    do_reset();
    push_stream(30);
    for (int k = 0; k < 50 && !(valid_o && pops_cyc.size() >= 3); k++) step();
    chk("p3_primed", 80'(valid_o), 80'd1);
    n = pops_cyc.size();
    stall_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_valid", 80'(valid_o), 80'd1);
      chk("stall_opcode", 80'(opcode_o), 80'(last_exp.op));
      chk("stall_pc", 80'(pc_o), 80'(last_exp.pc));
    end
    chk("stall_req_off", 80'(imem_req_o), 80'd0);
    chk("stall_nopop", 80'(pops_cyc.size()), 80'(n));
    stall_i = 1'b0;
    drain("p3_drain");
    mem[8'h40] = 32'hAAAA_1234;
    mem[8'h41] = 32'h5678_9ABC;
    lat = 3;
    do_reset();
    step();
    chk("p4_req", 80'(imem_req_o), 80'd1);
    flush_i = 1'b1;
    target_i = 32'h102;
    exp_push(16'h1234, 32'd0, 32'h102);
    exp_push(16'h5678, 32'd0, 32'h104);
    exp_push(16'h9ABC, 32'd0, 32'h106);
    step();
    flush_i = 1'b0;
    chk("discard_req", 80'(imem_req_o), 80'd1);
    chk("discard_addr", 80'(imem_address_o), 80'd0);
    chk("flush_valid", 80'(valid_o), 80'd0);
    for (int k = 0; k < 20 && imem_req_o; k++) step();
    for (int k = 0; k < 20 && !imem_req_o; k++) step();
    chk("redirect_addr", 80'(imem_address_o), 80'h100);
    drain("p4_drain");
    do_reset();
    step();
    chk("p5_req", 80'(imem_req_o), 80'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("p5_valid", 80'(valid_o), 80'd0);
    chk("p5_req_restart", 80'(imem_req_o), 80'd1);
    chk("p5_addr", 80'(imem_address_o), 80'd0);
    push_stream(4);
    drain("p5_drain");
    mem[8'h80] = 32'h7777_7778;
    mem[8'h81] = 32'h7779_777A;
    lat = 0;
    do_reset();
    push_stream(8);
    for (int k = 0; k < 50 && !(valid_o && pops_cyc.size() >= 3); k++) step();
    chk("p6_primed", 80'(valid_o), 80'd1);
    stall_i = 1'b1;
    flush_i = 1'b1;
    target_i = 32'h200;
    sb.delete();
    exp_push(16'h7777, 32'd0, 32'h200);
    exp_push(16'h7778, 32'd0, 32'h202);
    exp_push(16'h7779, 32'd0, 32'h204);
    step();
    chk("flush_stall_valid", 80'(valid_o), 80'd0);
    stall_i = 1'b0;
    flush_i = 1'b0;
    drain("p6_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch stage directly upstream of the decode stage. It issues 32-bit word reads to instruction memory and buffers the returned halfwords in a 6-entry queue. From that queue it assembles complete moxie instructions: a 16-bit opcode, plus a 32-bit immediate for long forms. It presents one instruction per cycle to decode with a valid flag, honours the pipeline stall, and redirects on branch flush.

## Interface
Parameters:
- RESET_VECTOR, 32'h00001000, byte address of the first instruction (halfword aligned).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- imem_req_o  out  1  read request; held until ack.
- imem_address_o  out  32  word address, bits [1:0] always 0.
- imem_data_i  in  32  read data, valid in the ack cycle; big-endian ([31:16] is the lower-address halfword).
- imem_ack_i  in  1  read complete.
- stall_i  in  1  decode not accepting; outputs must hold.
- flush_i  in  1  redirect to target_i.
- target_i  in  32  new PC, halfword aligned.
- opcode_o  out  16  instruction opcode.
- operand_o  out  32  immediate for long forms, else 0.
- pc_o  out  32  byte address of opcode_o.
- valid_o  out  1  opcode_o/operand_o/pc_o hold a real instruction.

## Operation
- Queue: 6 halfword entries plus count `cnt` (0..6). The head is the oldest entry. A pop of 1 or 3 entries and a push of 2 entries are allowed in the same cycle.
- Long-form opcodes (opcode[15:8]) carry the next two halfwords as the immediate, high half first: 01, 03, 08, 09, 0C, 0D, 1A, 1B, 1D, 1F, 20, 22, 24, 36, 37, 38, 39. All other opcodes are 1 halfword.
- Issue: when stall_i=0, flush_i=0, and the head instruction is complete (cnt>=1 for short, cnt>=3 for long):
  - pop it;
  - register opcode_o, operand_o, pc_o=head_pc, valid_o=1;
  - advance head_pc by 2 or 6.
- If stall_i=0 and no complete instruction is available, valid_o<=0 (bubble). Other outputs are don't-care.
- If stall_i=1, all four outputs hold and nothing is popped.
- Fetch FSM:
  - IDLE: if cnt<=4 after this cycle's pop and no flush, set imem_req_o=1 with imem_address_o=fetch_addr, go to WAIT.
  - WAIT: on imem_ack_i, push the word (2 halfwords), fetch_addr+=4, imem_req_o<=0, go to IDLE.
  - DISCARD: on imem_ack_i, drop the data, then start the request at the redirected fetch_addr.
  - The cnt<=4 rule guarantees a push never overflows.
- Odd start: when fetch begins at an address with bit1=1, the first returned word pushes only [15:0]. A skip flag is set at reset and flush from the start address bit 1.
- Flush (highest priority, regardless of stall):
  - cnt<=0;
  - head_pc<=target_i, fetch_addr<=target_i&~3, skip<=target_i[1];
  - valid_o<=0;
  - if in WAIT without ack this cycle, go to DISCARD with imem_req_o held and address unchanged (an address is never changed while req is high);
  - an ack in the flush cycle is dropped.
- Reset values: valid_o=0, imem_req_o=0, opcode_o=0, operand_o=0, pc_o=RESET_VECTOR, imem_address_o=RESET_VECTOR&~3, cnt=0, FSM=IDLE, head_pc=RESET_VECTOR, skip=RESET_VECTOR[1]. Reset mid-request abandons it and ignores any later ack until the next request.

## Timing
- One outstanding request maximum. imem_req_o rises on the first edge with rst_i low and falls on the edge that samples ack.
- Zero-wait memory (ack in the first req cycle): one word every 2 cycles, i.e. peak 1 halfword/cycle.
- Ack sampled at edge E writes the queue. valid_o for an instruction completed by that word rises at E+1.
- Flush sampled at edge F: valid_o=0 from F. The first instruction from the target is visible at the edge after the first post-flush ack.
- operand_o = {hw1, hw2} for long forms.

## Test plan
- Zero-wait memory, RESET_VECTOR=0, words 0x00000200, 0x0E120000 → valid instructions in order: opcode 0000 pc 0, 0200 pc 2, 0E12 pc 4, 0000 pc 6. No bubbles once the queue is primed.
- Long instruction straddling words: mem[0]=0x0000011A, mem[4]=0xDEADBEEF → opcode 0000 pc 0, then opcode 011A operand DEADBEEF pc 2. No valid_o for the middle halfwords.
- Hold stall_i=1 for 10 cycles with valid_o=1 → outputs frozen, imem_req_o stops once cnt reaches 5–6, no entries lost. Release → remaining instructions in order.
- Memory with 3-cycle ack delay, flush_i with target 0x102 during WAIT → the pending ack data is discarded, the next request address is 0x100, the first output is opcode mem[0x100][15:0] with pc 0x102.
- rst_i asserted during WAIT with ack arriving the next cycle → ack ignored, valid_o=0, fetch restarts at RESET_VECTOR&~3.
- Flush and stall asserted together → valid_o=0 at the next edge and the stall does not hold the old instruction.
